// File: rtl/cdc_loopback.sv
// Byte loopback buffer between the CPU transmit and receive streams.
// A DEPTH-entry circular FIFO with valid/ready handshakes on both sides and
// one cycle of latency from push to the byte appearing on the output.
// Optional feature macro: CDC_LOOPBACK_CRLF_EN -- when defined, every 0x0D
// popped from the FIFO is followed by an inserted 0x0A (LF) output byte.
module cdc_loopback #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [7:0]              in_data_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  output logic [7:0]              out_data_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    idle_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Pointers carry one extra MSB so full (MSBs differ) and empty are distinct.
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic [7:0]  mem_q [DEPTH];

  logic        push;
  logic        pop_data;
  logic        not_empty;
  logic        lf_state;

  // Occupancy is the pointer distance; wrap modulo 2*DEPTH keeps it exact.
  assign count_o    = wr_ptr_q - rd_ptr_q;
  assign not_empty  = (count_o != '0);
  assign in_ready_o = (count_o != DEPTH[AW:0]);
  assign push       = in_valid_i & in_ready_o;
  // A FIFO pop happens only while presenting buffered data, never during LF.
  assign pop_data   = ~lf_state & not_empty & out_ready_i;

  assign out_valid_o = lf_state | not_empty;
  assign idle_o      = ~not_empty & ~lf_state & ~in_valid_i;

  // Output byte: inserted LF, head of FIFO, or zero when nothing to show.
  always_comb begin
    out_data_o = 8'h00;
    if (lf_state) begin
      out_data_o = 8'h0A;
    end else if (not_empty) begin
      out_data_o = mem_q[rd_ptr_q[AW-1:0]];
    end
  end

  // Storage array; writes are suppressed in a reset cycle.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      mem_q[wr_ptr_q[AW-1:0]] <= in_data_i;
    end
  end

  // Pointer update; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_data) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

`ifdef CDC_LOOPBACK_CRLF_EN
  typedef enum logic {StData, StLf} state_e;
  state_e state_q;

  // Output FSM: a popped CR parks in StLf until the inserted LF is taken.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StData;
    end else begin
      unique case (state_q)
        StData: begin
          if (pop_data && (out_data_o == 8'h0D)) begin
            state_q <= StLf;
          end
        end
        StLf: begin
          if (out_ready_i) begin
            state_q <= StData;
          end
        end
        default: state_q <= StData;
      endcase
    end
  end

  assign lf_state = (state_q == StLf);
`else
  assign lf_state = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_loopback.sv
// Directed and scoreboarded bench for cdc_loopback (DEPTH = 8).
module tb_cdc_loopback;

  localparam int unsigned DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] count;
  logic       idle;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cdc_loopback #(.DEPTH(DEPTH)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_data_i  (in_data),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .out_data_o (out_data),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .count_o    (count),
    .idle_o     (idle)
  );

  typedef struct packed {
    logic       rst;
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       ir;
    logic       ov;
    logic [7:0] od;
    logic [3:0] cnt;
    logic       idle;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic v, input logic [7:0] d, input logic o);
    rst       = r;
    in_valid  = v;
    in_data   = d;
    out_ready = o;
  endtask

  function automatic vec_t mk(input logic r, input logic v, input logic [7:0] d,
                              input logic o, input logic ir, input logic ov,
                              input logic [7:0] od, input logic [3:0] cnt, input logic idl);
    vec_t x;
    x = '{rst: r, iv: v, id: d, ordy: o, ir: ir, ov: ov, od: od, cnt: cnt, idle: idl};
    return x;
  endfunction

  // Global watchdog so the bench can never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] sb_q[$];
    logic [7:0] prev_data;
    logic [7:0] rd;
    logic       prev_stall;
    int         idx;
    int         sent;
    int         recvd;
    int         cyc;

    drive(1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    tick();

    // Pre-edge expectations per cycle (state after previous edges).
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 8'h00, 4'd0, 1));  // reset state
    vecs.push_back(mk(1, 1, 8'h77, 1, 1, 0, 8'h00, 4'd0, 0));  // push in reset cycle ignored
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 8'h00, 4'd0, 1));  // ready pulse on empty
    vecs.push_back(mk(0, 1, 8'h41, 1, 1, 0, 8'h00, 4'd0, 0));  // push A
    vecs.push_back(mk(0, 1, 8'h42, 1, 1, 1, 8'h41, 4'd1, 0));  // A out, push B
    vecs.push_back(mk(0, 1, 8'h43, 1, 1, 1, 8'h42, 4'd1, 0));  // B out, push C
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'h43, 4'd1, 0));  // C out
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 8'h00, 4'd0, 1));  // drained

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].iv, vecs[i].id, vecs[i].ordy);
      #1;
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].ir));
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
      chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].od));
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d_idle", i), 32'(idle), 32'(vecs[i].idle));
      tick();
    end

    // Fill: 9 offered with no consumer, only 8 accepted.
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 1'b1, 8'(i), 1'b0);
      #1;
      chk($sformatf("fill%0d_in_ready", i), 32'(in_ready), (i < 8) ? 32'd1 : 32'd0);
      chk($sformatf("fill%0d_count", i), 32'(count), (i < 8) ? 32'(i) : 32'd8);
      tick();
    end
    drive(1'b0, 1'b1, 8'h08, 1'b0);
    #1;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_count", 32'(count), 32'd8);
    chk("full_head", 32'(out_data), 32'h00);
    // Full with valid and ready: pop only.
    drive(1'b0, 1'b1, 8'h08, 1'b1);
    #1;
    chk("full_pop_in_ready", 32'(in_ready), 32'd0);
    tick();
    drive(1'b0, 1'b1, 8'h08, 1'b0);
    #1;
    chk("after_pop_count", 32'(count), 32'd7);
    chk("after_pop_in_ready", 32'(in_ready), 32'd1);
    chk("after_pop_head", 32'(out_data), 32'h01);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    #1;
    chk("refill_count", 32'(count), 32'd8);
    chk("refill_in_ready", 32'(in_ready), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      #1;
      chk($sformatf("drain%0d_data", i), 32'(out_data), 32'(i));
      chk($sformatf("drain%0d_count", i), 32'(count), 32'(9 - i));
      tick();
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    #1;
    chk("drained_valid", 32'(out_valid), 32'd0);

    // Reset mid-transfer with 5 bytes buffered.
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 8'(8'hA0 + i), 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    #1;
    chk("pre_rst_count", 32'(count), 32'd5);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    #1;
    chk("post_rst_count", 32'(count), 32'd0);
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    chk("post_rst_idle", 32'(idle), 32'd1);
    chk("post_rst_data", 32'(out_data), 32'h00);
    drive(1'b0, 1'b1, 8'h55, 1'b0);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    #1;
    chk("post_rst_push_valid", 32'(out_valid), 32'd1);
    chk("post_rst_push_data", 32'(out_data), 32'h55);
    tick();

    // CR handling stream.
`ifdef CDC_LOOPBACK_CRLF_EN
    exp_q = '{8'h68, 8'h0D, 8'h0A, 8'h69};
`else
    exp_q = '{8'h68, 8'h0D, 8'h69};
`endif
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      drive(1'b0, idx < 3, (idx == 0) ? 8'h68 : (idx == 1) ? 8'h0D : 8'h69, 1'b1);
      #1;
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (in_valid && in_ready) idx++;
      tick();
    end
    chk("crlf_len", 32'(got_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      rd = (i < got_q.size()) ? got_q[i] : 8'hXX;
      chk($sformatf("crlf_byte%0d", i), 32'(rd), 32'(exp_q[i]));
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    #1;
    chk("crlf_idle", 32'(idle), 32'd1);

    // Random backpressure with a scoreboard queue.
    sent = 0;
    recvd = 0;
    cyc = 0;
    prev_stall = 1'b0;
    prev_data = 8'h00;
    while (recvd < 1000 && cyc < 20000) begin
      rd = 8'($urandom_range(0, 255));
      if (rd == 8'h0D) rd = 8'h0C;
      drive(1'b0, (sent < 1000) && ($urandom_range(0, 3) != 0), rd,
            $urandom_range(0, 2) != 0);
      #1;
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("rand_unexpected_pop", 32'd1, 32'd0);
        end else begin
          chk("rand_data", 32'(out_data), 32'(sb_q.pop_front()));
        end
        recvd++;
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(in_data);
        sent++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
      tick();
      cyc++;
    end
    chk("rand_received", 32'(recvd), 32'd1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
